if_prefetch_stage: RTL and testbench
====================================

IF_PREFETCH_STAGE -- requirements
Module: if_prefetch_stage

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, prefetch buffer entries; SHALL be a power of two, >= 2.
REQ-002 clk_i  input  1  clock; all state updates on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 boot_addr_i  input  32  first fetch address after reset; sampled in BOOT state.
REQ-005 instr_req_o  output  1  fetch request to instruction memory.
REQ-006 instr_addr_o  output  32  fetch address; SHALL stay stable while instr_req_o=1 and instr_gnt_i=0.
REQ-007 instr_gnt_i  input  1  request accepted this cycle.
REQ-008 instr_rvalid_i  input  1  read data valid for the oldest granted request.
REQ-009 instr_rdata_i  input  32  read data.
REQ-010 redirect_i  input  1  branch/jump taken; flush and refetch.
REQ-011 redirect_addr_i  input  32  new fetch target, valid with redirect_i.
REQ-012 id_ready_i  input  1  ID stage accepts the instruction this cycle.
REQ-013 instr_valid_o  output  1  instr_rdata_o/pc_o hold a valid instruction.
REQ-014 instr_rdata_o  output  32  instruction at FIFO head.
REQ-015 pc_o  output  32  address of the instruction at FIFO head.

Function
REQ-016 FSM states: BOOT, FETCH, WAIT, FLUSH.
- BOOT -> FETCH unconditionally, loading fetch_pc = boot_addr_i.
- FETCH: instr_req_o=1 when credit available; gnt -> WAIT.
- WAIT: instr_req_o=0; rvalid -> FETCH.
- FLUSH: instr_req_o=0; rvalid (discarded) -> FETCH.
REQ-017 At most one outstanding request; no new request while in WAIT or FLUSH.
REQ-018 Credit SHALL be fifo_count + outstanding < FIFO_DEPTH, so a response never finds the FIFO full.
REQ-019 On grant, fetch_pc SHALL advance by 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-020 On rvalid in WAIT, {instr_rdata_i, address of the granted request} SHALL be pushed. It SHALL appear on the outputs the next cycle (1-cycle rvalid-to-valid latency).
REQ-021 Pop SHALL occur when instr_valid_o=1 and id_ready_i=1. Push and pop in the same cycle leave the count unchanged.
REQ-022 instr_valid_o SHALL equal (fifo_count != 0).
REQ-023 Redirect, when redirect_i=1, takes priority over all same-cycle events:
- FIFO is emptied; any same-cycle push and pop are dropped.
- fetch_pc = redirect_addr_i.
- State goes to FLUSH if a request is outstanding (WAIT), or if a grant occurs that cycle; otherwise to FETCH.
REQ-024 A redirect arriving while in FLUSH SHALL update fetch_pc and keep the state in FLUSH.
REQ-025 A redirect in BOOT SHALL be ignored; boot_addr_i wins.
REQ-026 instr_valid_o SHALL be 0 in the cycle after a redirect. The first post-redirect instruction SHALL carry pc_o = redirect_addr_i.
REQ-027 A redirect SHALL be accepted regardless of id_ready_i. instr_valid_o=1 with id_ready_i=0 SHALL hold the outputs stable.

Reset
REQ-028 While rst_ni=0:
- state = BOOT, fetch_pc = 0, FIFO empty, no outstanding request.
- instr_req_o = 0, instr_addr_o = 0, instr_valid_o = 0, instr_rdata_o = 0, pc_o = 0.
REQ-029 Reset asserted mid-transaction SHALL abandon the outstanding request. Any rvalid during reset or in BOOT SHALL be ignored.

Structure
REQ-030 State enum if_state_e (BOOT, FETCH, WAIT, FLUSH) and constant INSTR_W = 32 SHALL live in riscv_cpu_pkg.
REQ-031 The buffer SHALL be a sub-module prefetch_fifo (parameters DEPTH and WIDTH = 64 for {pc, instr}; ports push, pop, flush, full, empty, count). Control logic stays in if_prefetch_stage.

Verification
REQ-032 Boot: boot_addr_i=0x00000080, gnt same cycle, rvalid one cycle later, id_ready_i=1 -> addresses 0x80, 0x84, 0x88 requested in order; pc_o sequence 0x80, 0x84, 0x88.
REQ-033 Backpressure: FIFO_DEPTH=2, id_ready_i=0 -> exactly two grants, then instr_req_o=0 with instr_valid_o=1 held. Release id_ready_i -> requests resume at 0x88.
REQ-034 Redirect with outstanding request: redirect_i=1, redirect_addr_i=0x200 while in WAIT -> next rvalid discarded, instr_valid_o=0, next request addr 0x200, first pc_o=0x200.
REQ-035 Simultaneous redirect + rvalid + pop in FETCH -> FIFO empty next cycle, state FETCH, instr_addr_o=redirect target.
REQ-036 Wrap: redirect_addr_i=0xFFFFFFFC -> subsequent request addr 0x00000000.
REQ-037 Reset asserted in WAIT, rvalid arriving after release during BOOT -> no push, instr_valid_o=0, first request at boot_addr_i.

Source files
------------

// File: rtl/riscv_cpu_pkg.sv
// Shared core types: fetch FSM states, word width, fetch-buffer entry.
// Imported by the IF prefetch stage and its buffer.
package riscv_cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int ENTRY_W = 2 * INSTR_W;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    WAIT,
    FLUSH
  } if_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [INSTR_W-1:0] next_pc(
    input logic [INSTR_W-1:0] pc
  );
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Circular prefetch buffer; DEPTH must be a power of two.
// Ports: push/pop/flush, wdata/rdata (head), full, empty, count.
module prefetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/if_prefetch_stage.sv
// IF prefetch: one outstanding fetch, credit-gated, redirect flush.
// Ports: boot/redirect addr in, instr mem req/gnt/rvalid, ID head out.
module if_prefetch_stage
  import riscv_cpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [INSTR_W-1:0] boot_addr_i,
  output logic               instr_req_o,
  output logic [INSTR_W-1:0] instr_addr_o,
  input  logic               instr_gnt_i,
  input  logic               instr_rvalid_i,
  input  logic [INSTR_W-1:0] instr_rdata_i,
  input  logic               redirect_i,
  input  logic [INSTR_W-1:0] redirect_addr_i,
  input  logic               id_ready_i,
  output logic               instr_valid_o,
  output logic [INSTR_W-1:0] instr_rdata_o,
  output logic [INSTR_W-1:0] pc_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  if_state_e          state_q, state_d;
  logic [INSTR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [INSTR_W-1:0] req_pc_q, req_pc_d;
  logic               push, pop, flush;
  logic               full, empty;
  logic [CW-1:0]      count;
  logic [CW:0]        used;
  logic               outstanding;
  logic               credit;
  logic               grant;
  fetch_entry_t       wentry, rentry;

  assign outstanding = (state_q == WAIT) || (state_q == FLUSH);
  assign used   = {1'b0, count} + {{CW{1'b0}}, outstanding};
  assign credit = !full && (used < (CW + 1)'(FIFO_DEPTH));

  assign instr_req_o  = (state_q == FETCH) && credit;
  assign instr_addr_o = fetch_pc_q;
  assign grant        = instr_req_o && instr_gnt_i;

  assign instr_valid_o = !empty;
  assign instr_rdata_o = empty ? '0 : rentry.instr;
  assign pc_o          = empty ? '0 : rentry.pc;

  assign wentry = '{pc: req_pc_q, instr: instr_rdata_i};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    push       = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;
    if (state_q == BOOT) begin
      state_d    = FETCH;
      fetch_pc_d = boot_addr_i;
    end else if (redirect_i) begin
      flush      = 1'b1;
      fetch_pc_d = redirect_addr_i;
      // FLUSH only while a response is still owed after this edge;
      // a same-cycle rvalid retires the old request.
      if ((outstanding && !instr_rvalid_i) || grant)
        state_d = FLUSH;
      else
        state_d = FETCH;
    end else begin
      pop = instr_valid_o && id_ready_i;
      unique case (1'b1)
        state_q == FETCH: begin
          if (grant) begin
            state_d    = WAIT;
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = next_pc(fetch_pc_q);
          end
        end
        state_q == WAIT: begin
          if (instr_rvalid_i) begin
            push    = 1'b1;
            state_d = FETCH;
          end
        end
        state_q == FLUSH: begin
          if (instr_rvalid_i) state_d = FETCH;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= BOOT;
      fetch_pc_q <= '0;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  prefetch_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (wentry),
    .rdata (rentry),
    .full  (full),
    .empty (empty),
    .count (count)
  );

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Bench for if_prefetch_stage: memory responder, queue model,
// per-cycle compare and directed scenario checks.
module tb_if_prefetch_stage;

  localparam int DEPTH = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] boot_addr;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        id_ready;
  logic        valid;
  logic [31:0] instr_o;
  logic [31:0] pc_out;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  if_prefetch_stage #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .boot_addr_i    (boot_addr),
    .instr_req_o    (instr_req),
    .instr_addr_o   (instr_addr),
    .instr_gnt_i    (gnt),
    .instr_rvalid_i (rvalid),
    .instr_rdata_i  (rdata),
    .redirect_i     (redirect),
    .redirect_addr_i(redirect_addr),
    .id_ready_i     (id_ready),
    .instr_valid_o  (valid),
    .instr_rdata_o  (instr_o),
    .pc_o           (pc_out)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // memory responder
  bit          gnt_en = 1'b1;
  bit          rv_force = 1'b0;
  int          lat = 1;
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = '0;
  logic        resp_rv = 1'b0;
  logic        s_g, s_rv;
  logic [31:0] s_addr;

  assign gnt    = instr_req & gnt_en;
  assign rvalid = resp_rv | rv_force;
  assign rdata  = rv_force ? 32'hBAD0_0000 :
                  (resp_rv ? instr_of(paddr) : 32'h0);

  always @(posedge clk_i) begin
    s_g    = gnt;
    s_rv   = resp_rv;
    s_addr = instr_addr;
    #1;
    if (s_rv) pend = 1'b0;
    if (pend && cnt > 0) cnt--;
    if (s_g) begin
      pend  = 1'b1;
      paddr = s_addr;
      cnt   = lat - 1;
    end
    resp_rv = pend && (cnt == 0);
  end

  // reference model
  logic [63:0] m_q[$];
  logic [31:0] m_pc, m_req_pc;
  int          m_out;
  bit          m_drop, m_boot;
  bit          m_g, m_rv;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_q.delete();
      m_pc = '0; m_req_pc = '0;
      m_out = 0; m_drop = 1'b0; m_boot = 1'b1;
    end else if (m_boot) begin
      m_boot = 1'b0;
      m_pc   = boot_addr;
    end else begin
      m_g  = gnt;
      m_rv = rvalid && (m_out > 0);
      if (redirect) begin
        m_q.delete();
        m_pc   = redirect_addr;
        m_out  = m_out - (m_rv ? 1 : 0) + (m_g ? 1 : 0);
        m_drop = (m_out > 0);
      end else begin
        if (m_q.size() > 0 && id_ready) void'(m_q.pop_front());
        if (m_rv) begin
          if (!m_drop) m_q.push_back({m_req_pc, rdata});
          m_out--;
          m_drop = 1'b0;
        end
        if (m_g) begin
          m_req_pc = m_pc;
          m_pc     = m_pc + 32'd4;
          m_out++;
        end
      end
    end
  end

  // logs of granted fetch addresses and consumed pcs
  logic [31:0] grant_log[$];
  logic [31:0] pop_log[$];

  always @(posedge clk_i) begin
    if (rst_ni && instr_req && gnt) grant_log.push_back(instr_addr);
    if (rst_ni && valid && id_ready && !redirect)
      pop_log.push_back(pc_out);
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] nth(input logic [31:0] q[$],
                                      input int i);
    return (q.size() > i) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  logic        e_req;
  logic [63:0] e_head;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      chk("rst_req", instr_req, 0);
      chk("rst_addr", instr_addr, 0);
      chk("rst_valid", valid, 0);
      chk("rst_instr", instr_o, 0);
      chk("rst_pc", pc_out, 0);
    end else begin
      e_req = !m_boot && m_out == 0 && (m_q.size() + m_out < DEPTH);
      chk("req", instr_req, e_req);
      if (e_req) chk("addr", instr_addr, m_pc);
      chk("valid", valid, m_q.size() != 0);
      if (m_q.size() != 0) begin
        e_head = m_q[0];
        chk("pc", pc_out, e_head[63:32]);
        chk("instr", instr_o, e_head[31:0]);
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic restart(input logic [31:0] ba, input int l);
    rst_ni   = 1'b0;
    redirect = 1'b0;
    rv_force = 1'b0;
    boot_addr = ba;
    tick(3);
    lat = l;
    grant_log.delete();
    pop_log.delete();
    rst_ni = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0;
    boot_addr = 32'h80;
    redirect = 1'b0;
    redirect_addr = '0;
    id_ready = 1'b1;
    tick(2);

    // boot and steady streaming
    restart(32'h80, 1);
    tick(10);
    chk("boot_g0", nth(grant_log, 0), 32'h80);
    chk("boot_g1", nth(grant_log, 1), 32'h84);
    chk("boot_g2", nth(grant_log, 2), 32'h88);
    chk("boot_p0", nth(pop_log, 0), 32'h80);
    chk("boot_p1", nth(pop_log, 1), 32'h84);
    chk("boot_p2", nth(pop_log, 2), 32'h88);

    // backpressure fills the buffer, then resumes
    id_ready = 1'b0;
    restart(32'h80, 1);
    tick(8);
    @(negedge clk_i);
    chk("bp_grants", grant_log.size(), 2);
    chk("bp_req", instr_req, 0);
    chk("bp_valid", valid, 1);
    chk("bp_pc", pc_out, 32'h80);
    tick(1);
    id_ready = 1'b1;
    tick(1);
    @(negedge clk_i);
    chk("bp_resume_req", instr_req, 1);
    chk("bp_resume_addr", instr_addr, 32'h88);
    tick(6);

    // redirect while a request is outstanding
    restart(32'h80, 4);
    tick(2);
    redirect = 1'b1;
    redirect_addr = 32'h200;
    tick(1);
    redirect = 1'b0;
    @(negedge clk_i);
    chk("rw_valid", valid, 0);
    chk("rw_req", instr_req, 0);
    tick(15);
    chk("rw_g1", nth(grant_log, 1), 32'h200);
    chk("rw_p0", nth(pop_log, 0), 32'h200);

    // redirect + stray rvalid + pop together in FETCH
    id_ready = 1'b0;
    restart(32'h80, 1);
    tick(8);
    redirect = 1'b1;
    redirect_addr = 32'h300;
    rv_force = 1'b1;
    id_ready = 1'b1;
    @(negedge clk_i);
    chk("rf_valid_pre", valid, 1);
    tick(1);
    redirect = 1'b0;
    rv_force = 1'b0;
    @(negedge clk_i);
    chk("rf_valid", valid, 0);
    chk("rf_req", instr_req, 1);
    chk("rf_addr", instr_addr, 32'h300);
    tick(6);
    chk("rf_g2", nth(grant_log, 2), 32'h300);
    chk("rf_p0", nth(pop_log, 0), 32'h300);

    // address wrap
    gnt_en = 1'b0;
    restart(32'h80, 1);
    tick(3);
    redirect = 1'b1;
    redirect_addr = 32'hFFFF_FFFC;
    tick(1);
    redirect = 1'b0;
    gnt_en = 1'b1;
    tick(8);
    chk("wrap_g0", nth(grant_log, 0), 32'hFFFF_FFFC);
    chk("wrap_g1", nth(grant_log, 1), 32'h0);
    chk("wrap_p0", nth(pop_log, 0), 32'hFFFF_FFFC);
    chk("wrap_p1", nth(pop_log, 1), 32'h0);

    // reset mid-request, stale rvalid during BOOT
    restart(32'h80, 2);
    tick(2);
    rst_ni = 1'b0;
    boot_addr = 32'h400;
    grant_log.delete();
    pop_log.delete();
    tick(1);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rs_boot_valid", valid, 0);
    chk("rs_boot_req", instr_req, 0);
    tick(1);
    @(negedge clk_i);
    chk("rs_valid", valid, 0);
    chk("rs_req", instr_req, 1);
    chk("rs_addr", instr_addr, 32'h400);
    tick(6);
    chk("rs_g0", nth(grant_log, 0), 32'h400);
    chk("rs_p0", nth(pop_log, 0), 32'h400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
